// File: rtl/gemm_pkg.sv
// gemm_pkg: shared constants and types for the GEMM result path.
//   result_lanes_gp      - results packed per output word
//   result_lane_width_gp - width of one lane in the output word
//   result_width_gp      - width of a raw result from compute_engine
//   rp_state_t           - result_packer FSM encoding (visible on o_pack_state)
package gemm_pkg;

    localparam int result_lanes_gp      = 8;
    localparam int result_lane_width_gp = 32;
    localparam int result_width_gp      = 24;
    localparam int result_word_width_gp = result_lanes_gp * result_lane_width_gp;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } rp_state_t;

    // Results are unsigned; upper lane bits are zero.
    function automatic logic [result_lane_width_gp-1:0] zext_result(
        input logic [result_width_gp-1:0] r
    );
        return {{(result_lane_width_gp - result_width_gp){1'b0}}, r};
    endfunction

endpackage

// File: rtl/result_fifo_sync.sv
// result_fifo_sync: single-clock FIFO buffering compute_engine results.
//   clk, reset_n      - clock, synchronous active-low reset
//   wr_en, wr_data    - write strobe/data; ignored (and flagged) while full
//   rd_en, rd_data    - pop strobe; rd_data shows the head entry (show-ahead)
//   empty             - no entries (decoded from the count register)
//   full, afull       - registered flags computed from the post-edge count
//   overflow          - sticky, set by a write attempted while full
module result_fifo_sync #(
    parameter int DEPTH        = 64,
    parameter int AFULL_MARGIN = 8,
    parameter int WIDTH        = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             afull,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;

    // Push is gated by the registered full flag, so a same-cycle pop
    // never makes room for a write that arrives at full.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            afull    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            // Flags describe the count after this edge.
            full  <= (count_nxt == FULL_LVL);
            afull <= (count_nxt >= AFULL_LVL);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; only pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/result_packer.sv
// result_packer: buffers 24-bit compute_engine results, zero-extends them to
// 32-bit lanes and packs eight per 256-bit word for the write-back path.
// A flush (tile done) drains everything and marks the final word as last.
//   i_clk, i_reset_n              - clock, synchronous active-low reset
//   i_result_data/_valid          - result stream in
//   o_result_full/_afull          - back-pressure to compute_engine
//   i_flush                       - tile-complete pulse
//   o_wr_data/_valid/_last        - packed word out, i_wr_ready handshake
//   o_flush_done                  - one-cycle pulse when the flush completes
//   o_overflow                    - sticky, write dropped while full
//   o_result_count                - accepted results since reset (mod 2^16)
//   o_pack_state                  - debug FSM state
module result_packer
    import gemm_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [result_width_gp-1:0]      i_result_data,
    input  logic                            i_result_valid,
    output logic                            o_result_full,
    output logic                            o_result_afull,
    input  logic                            i_flush,
    output logic [result_word_width_gp-1:0] o_wr_data,
    output logic                            o_wr_valid,
    input  logic                            i_wr_ready,
    output logic                            o_wr_last,
    output logic                            o_flush_done,
    output logic                            o_overflow,
    output logic [15:0]                     o_result_count,
    output logic [1:0]                      o_pack_state
);

    localparam int LCW = $clog2(result_lanes_gp) + 1;
    localparam int LIW = $clog2(result_lanes_gp);
    localparam logic [LCW-1:0] LC_FULL = LCW'(result_lanes_gp);

    rp_state_t state;
    rp_state_t state_nxt;

    logic [result_width_gp-1:0] fifo_data;
    logic                       fifo_empty;
    logic                       pop;

    logic [result_lanes_gp-1:0][result_width_gp-1:0] lanes;
    logic [LCW-1:0] lc;
    logic [LCW-1:0] lc_base;
    logic           stall_q;
    logic           last_q;
    logic           last_now;
    logic           hs;
    logic [15:0]    result_count;

    result_fifo_sync #(
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (AFULL_MARGIN),
        .WIDTH        (result_width_gp)
    ) u_fifo (
        .clk      (i_clk),
        .reset_n  (i_reset_n),
        .wr_en    (i_result_valid),
        .wr_data  (i_result_data),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .empty    (fifo_empty),
        .full     (o_result_full),
        .afull    (o_result_afull),
        .overflow (o_overflow)
    );

    // During a flush, whatever is in the lanes with nothing left behind it
    // is the final word (partial or complete).
    assign last_now = (state == ST_FLUSH) && fifo_empty && (lc != '0);

    // stall_q holds a presented word valid while the sink is not ready, even
    // if a new write makes the FIFO non-empty and would otherwise drop the
    // partial-word condition. lc and lanes cannot change during a stall.
    assign o_wr_valid = (lc == LC_FULL) || last_now || stall_q;

    // Once last has been presented it stays up until the handshake. It may
    // still rise during a stall if the flush begins while a full word waits,
    // since that word is then the final one of the tile.
    assign o_wr_last = last_now || (stall_q && last_q);

    assign hs = o_wr_valid && i_wr_ready;

    // A pop is allowed whenever no word is presented, or the presented word
    // is leaving this cycle (which frees lane 0 for the popped entry).
    assign pop     = !fifo_empty && (!o_wr_valid || i_wr_ready);
    assign lc_base = hs ? '0 : lc;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:  if (i_flush) state_nxt = ST_FLUSH;
            ST_FLUSH: begin
                if ((hs && o_wr_last) || (fifo_empty && lc == '0))
                    state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_FILL;
            default:  state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= ST_FILL;
            lanes        <= '0;
            lc           <= '0;
            stall_q      <= 1'b0;
            last_q       <= 1'b0;
            result_count <= '0;
        end else begin
            state   <= state_nxt;
            stall_q <= o_wr_valid && !i_wr_ready;
            last_q  <= o_wr_last;
            if (pop) begin
                lanes[lc_base[LIW-1:0]] <= fifo_data;
                lc <= lc_base + LCW'(1);
            end else begin
                lc <= lc_base;
            end
            if (i_result_valid && !o_result_full)
                result_count <= result_count + 16'd1;
        end
    end

    // Lanes at or above lc are stale after a handshake; present them as zero.
    for (genvar k = 0; k < result_lanes_gp; k++) begin : g_lane
        assign o_wr_data[k*result_lane_width_gp +: result_lane_width_gp] =
            (lc > LCW'(k)) ? zext_result(lanes[k]) : '0;
    end

    assign o_flush_done   = (state == ST_DONE);
    assign o_result_count = result_count;
    assign o_pack_state   = state;

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic [23:0]  i_result_data;
    logic         i_result_valid;
    logic         o_result_full;
    logic         o_result_afull;
    logic         i_flush;
    logic [255:0] o_wr_data;
    logic         o_wr_valid;
    logic         i_wr_ready;
    logic         o_wr_last;
    logic         o_flush_done;
    logic         o_overflow;
    logic [15:0]  o_result_count;
    logic [1:0]   o_pack_state;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    result_packer #(.DEPTH(64), .AFULL_MARGIN(8)) dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_result_data  (i_result_data),
        .i_result_valid (i_result_valid),
        .o_result_full  (o_result_full),
        .o_result_afull (o_result_afull),
        .i_flush        (i_flush),
        .o_wr_data      (o_wr_data),
        .o_wr_valid     (o_wr_valid),
        .i_wr_ready     (i_wr_ready),
        .o_wr_last      (o_wr_last),
        .o_flush_done   (o_flush_done),
        .o_overflow     (o_overflow),
        .o_result_count (o_result_count),
        .o_pack_state   (o_pack_state)
    );

    // Handshake monitor: inputs change just after posedge, so the negedge
    // sees exactly what the next posedge will act on.
    logic [255:0] words[$];
    logic         lasts[$];
    int           done_cnt  = 0;
    int           valid_cnt = 0;

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_wr_valid) valid_cnt++;
            if (o_wr_valid && i_wr_ready) begin
                words.push_back(o_wr_data);
                lasts.push_back(o_wr_last);
            end
            if (o_flush_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        i_reset_n      = 1'b0;
        i_result_data  = '0;
        i_result_valid = 1'b0;
        i_flush        = 1'b0;
        i_wr_ready     = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
    endtask

    task automatic write(input logic [23:0] d);
        i_result_valid = 1'b1;
        i_result_data  = d;
        tick();
        i_result_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, " ctl"}, {o_wr_valid, o_wr_last, o_result_full, o_result_afull,
                            o_flush_done, o_overflow, o_result_count, o_pack_state}, '0);
        chk({name, " data"}, o_wr_data, '0);
    endtask

    typedef struct {
        int             n;
        logic [15:0][23:0] d;
        logic           fl;
        int             exp_words;
        logic [255:0]   exp_last;
        logic           exp_lflag;
        int             exp_done;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int wb, db, vb;
        logic [255:0] ew;

        // ---- vector table ----
        tbl[0].n = 8;  tbl[0].fl = 1'b0; tbl[0].exp_words = 1; tbl[0].exp_lflag = 1'b0; tbl[0].exp_done = 0;
        tbl[0].d = '0;
        for (int i = 0; i < 8; i++) tbl[0].d[i] = 24'(i + 1);
        tbl[0].exp_last = 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

        tbl[1].n = 3;  tbl[1].fl = 1'b1; tbl[1].exp_words = 1; tbl[1].exp_lflag = 1'b1; tbl[1].exp_done = 1;
        tbl[1].d = '0;
        tbl[1].d[0] = 24'hABCDEF; tbl[1].d[1] = 24'h000001; tbl[1].d[2] = 24'h000002;
        tbl[1].exp_last = 256'h00000000_00000000_00000000_00000000_00000000_00000002_00000001_00abcdef;

        tbl[2].n = 16; tbl[2].fl = 1'b1; tbl[2].exp_words = 2; tbl[2].exp_lflag = 1'b1; tbl[2].exp_done = 1;
        tbl[2].d = '0;
        for (int i = 0; i < 16; i++) tbl[2].d[i] = 24'(16 + i);
        tbl[2].exp_last = 256'h0000001f_0000001e_0000001d_0000001c_0000001b_0000001a_00000019_00000018;

        tbl[3].n = 0;  tbl[3].fl = 1'b1; tbl[3].exp_words = 0; tbl[3].exp_lflag = 1'b0; tbl[3].exp_done = 1;
        tbl[3].d = '0; tbl[3].exp_last = '0;

        tbl[4].n = 9;  tbl[4].fl = 1'b1; tbl[4].exp_words = 2; tbl[4].exp_lflag = 1'b1; tbl[4].exp_done = 1;
        tbl[4].d = '0;
        for (int i = 0; i < 9; i++) tbl[4].d[i] = 24'hF00000 + 24'(i);
        tbl[4].exp_last = 256'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00f00008;

        // ---- reset state ----
        do_reset();
        chk_reset_outs("reset");

        // ---- table-driven runs ----
        for (int v = 0; v < 5; v++) begin
            do_reset();
            wb = words.size();
            db = done_cnt;
            i_wr_ready = 1'b1;
            for (int i = 0; i < tbl[v].n; i++) write(tbl[v].d[i]);
            if (tbl[v].fl) begin
                i_flush = 1'b1;
                tick();
                i_flush = 1'b0;
            end
            repeat (20) tick();
            chk($sformatf("v%0d words", v), 256'(words.size() - wb), 256'(tbl[v].exp_words));
            if (words.size() - wb == tbl[v].exp_words && tbl[v].exp_words > 0) begin
                chk($sformatf("v%0d last word", v), words[words.size()-1], tbl[v].exp_last);
                chk($sformatf("v%0d last flag", v), 256'(lasts[lasts.size()-1]), 256'(tbl[v].exp_lflag));
                if (tbl[v].exp_words > 1)
                    chk($sformatf("v%0d first flag", v), 256'(lasts[wb]), 256'(0));
            end
            chk($sformatf("v%0d flush_done", v), 256'(done_cnt - db), 256'(tbl[v].exp_done));
            chk($sformatf("v%0d state", v), 256'(o_pack_state), 256'(0));
        end

        // ---- packing latency and output stability ----
        do_reset();
        for (int i = 0; i < 8; i++) write(24'(i + 1));
        chk("lat valid t+7", 256'(o_wr_valid), 256'(0));
        tick();
        chk("lat valid t+8", 256'(o_wr_valid), 256'(1));
        chk("lat data", o_wr_data, tbl[0].exp_last);
        chk("lat last", 256'(o_wr_last), 256'(0));
        tick();
        chk("stall valid", 256'(o_wr_valid), 256'(1));
        chk("stall data", o_wr_data, tbl[0].exp_last);
        i_wr_ready = 1'b1;
        tick();
        chk("after hs valid", 256'(o_wr_valid), 256'(0));

        // ---- back-pressure, full, overflow ----
        do_reset();
        for (int i = 0; i < 72; i++) begin
            int cnt;
            write(24'(i + 1));
            cnt = i + 1 - ((i < 8) ? i : 8);
            chk($sformatf("bp afull w%0d", i + 1), 256'(o_result_afull), 256'(cnt >= 56));
            chk($sformatf("bp full w%0d", i + 1), 256'(o_result_full), 256'(cnt == 64));
        end
        chk("bp ovf before", 256'(o_overflow), 256'(0));
        write(24'd73);
        chk("bp ovf", 256'(o_overflow), 256'(1));
        chk("bp full held", 256'(o_result_full), 256'(1));
        chk("bp count", 256'(o_result_count), 256'(72));
        wb = words.size();
        i_wr_ready = 1'b1;
        repeat (100) tick();
        chk("bp words", 256'(words.size() - wb), 256'(9));
        if (words.size() - wb == 9) begin
            for (int w = 0; w < 9; w++) begin
                ew = '0;
                for (int k = 0; k < 8; k++) ew[k*32 +: 32] = 32'(w * 8 + k + 1);
                chk($sformatf("bp word%0d", w), words[wb + w], ew);
                chk($sformatf("bp word%0d last", w), 256'(lasts[wb + w]), 256'(0));
            end
        end
        chk("bp ovf sticky", 256'(o_overflow), 256'(1));

        // ---- empty flush, second flush during ST_FLUSH ignored ----
        do_reset();
        i_wr_ready = 1'b1;
        vb = valid_cnt;
        i_flush = 1'b1;
        tick();
        chk("ef state flush", 256'(o_pack_state), 256'(1));
        chk("ef done early", 256'(o_flush_done), 256'(0));
        tick();
        i_flush = 1'b0;
        chk("ef done", 256'(o_flush_done), 256'(1));
        chk("ef state done", 256'(o_pack_state), 256'(2));
        tick();
        chk("ef done pulse", 256'(o_flush_done), 256'(0));
        chk("ef state fill", 256'(o_pack_state), 256'(0));
        tick();
        chk("ef ignored", 256'(o_pack_state), 256'(0));
        chk("ef no word", 256'(valid_cnt - vb), 256'(0));

        // ---- reset mid-word ----
        do_reset();
        i_wr_ready = 1'b1;
        for (int i = 0; i < 5; i++) write(24'h000100 + 24'(i));
        db = done_cnt;
        i_reset_n = 1'b0;
        tick();
        chk_reset_outs("mid reset");
        i_reset_n = 1'b1;
        wb = words.size();
        for (int i = 0; i < 8; i++) write(24'h000021 + 24'(i));
        repeat (15) tick();
        chk("mid words", 256'(words.size() - wb), 256'(1));
        if (words.size() - wb == 1)
            chk("mid word", words[wb],
                256'h00000028_00000027_00000026_00000025_00000024_00000023_00000022_00000021);
        chk("mid count", 256'(o_result_count), 256'(8));
        chk("mid no done", 256'(done_cnt - db), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
